id_ex_hazard_reg: RTL
=====================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with integrated hazard detection and branch flush.
//  Captures decoded fields from ID and drives EX, including ex_src_1/ex_src_2 and
//  wb/mem controls that feed the forwarding unit.
//  Detects RAW hazards: load-use when forwarding is on; all EX/MEM producers when it is off.
//  On a hazard it freezes IF and IF/ID and inserts bubbles. Keeps saturating stall/flush counters.
// PARAMETERS
//  DATA_W  32  width of operand values and PC
//  CNT_W   16  width of stall_cnt / flush_cnt (saturating)
// PORTS
//  clk             in   1       rising-edge clock (single clock domain)
//  rst             in   1       synchronous, active-high reset
//  fwd_en          in   1       1 = forwarding unit active downstream
//  branch_taken    in   1       EX resolved a taken branch this cycle
//  id_valid        in   1       ID holds a real instruction
//  id_src_1        in   4       Rn index
//  id_src_2        in   4       Rm/Rd index (stores)
//  id_two_src      in   1       instruction reads id_src_2
//  id_dst          in   4       destination register
//  id_wb_en/id_mem_r_en/id_mem_w_en/id_b/id_s/id_imm  in 1 each  decoded controls
//  id_exe_cmd      in   4       ALU command
//  id_val_rn       in   DATA_W  register-file value of Rn
//  id_val_rm       in   DATA_W  register-file value of Rm
//  id_shift_op     in   12      shifter operand
//  id_simm24       in   24      branch offset
//  id_status       in   4       NZCV from status register
//  id_pc           in   DATA_W  PC+4 of ID instruction
//  mem_dst         in   4       destination held in the EX/MEM register
//  mem_wb_en       in   1       write-back enable held in the EX/MEM register
//  hazard          out  1       combinational; freezes PC and IF/ID
//  ex_valid        out  1       EX holds a real instruction
//  ex_<field>      out  as id_  registered copy of each id_ field listed above
//  stall_cnt       out  CNT_W   bubbles inserted due to hazard
//  flush_cnt       out  CNT_W   bubbles inserted due to branch_taken
// BEHAVIOUR
//  Reset:
//   - On rst=1 at a clock edge, all ex_* outputs, ex_valid and both counters go to 0.
//   - hazard is 0 while rst=1.
//  Hazard evaluation (combinational, from current ID inputs and registered EX state):
//   - chk1 = id_valid & ~id_b.
//   - chk2 = id_valid & id_two_src.
//   - match_ex(s)  = ex_valid & ex_wb_en & (s == ex_dst).
//   - match_mem(s) = mem_wb_en & (s == mem_dst).
//   - fwd_en=1: hazard = ex_mem_r_en & ((chk1 & match_ex(src_1)) | (chk2 & match_ex(src_2))).
//   - fwd_en=0: hazard = (chk1 & (match_ex(src_1) | match_mem(src_1))) | (chk2 & (match_ex(src_2) | match_mem(src_2))).
//   - branch_taken=1 forces hazard=0, because the ID instruction is being killed.
//  Register update, one cycle latency ID->EX; priority rst > branch_taken > hazard > load:
//   - branch_taken: load a bubble and increment flush_cnt.
//   - hazard: load a bubble and increment stall_cnt. The ID inputs stay held because IF/ID is frozen.
//     They are re-evaluated next cycle, so a load-use hazard with forwarding costs exactly 1 bubble.
//   - otherwise: every ex_* field takes its id_* value and ex_valid takes id_valid.
//   - Bubble: ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b and ex_s all go to 0.
//     The data fields and src/dst indices also go to 0.
//  Counters:
//   - Both saturate at all-ones and never wrap.
//   - At most one counter increments per cycle.
//  Invalid or bubbled ID (id_valid=0): never raises hazard and propagates as ex_valid=0.
//  Register R15 indices are compared like any other; there is no special case.
//  Mid-operation reset clears all pipeline and counter state on the same edge. No pending stall survives.
// TESTING
//  - Reset: rst=1 for 2 cycles with random id_* -> all ex_* =0, ex_valid=0, counters=0, hazard=0.
//  - Pass-through: fwd_en=1, no dependencies, id_dst=3, id_val_rn=32'h1234 ->
//    next cycle ex_dst=3, ex_val_rn=32'h1234, ex_valid=1, hazard never 1.
//  - Load-use: LDR r2 in EX (ex_mem_r_en=1, ex_dst=2), ID src_1=2, fwd_en=1 -> hazard=1 for 1 cycle.
//    One bubble is inserted (ex_valid=0), stall_cnt=1, then the ADD enters EX.
//  - No forwarding: fwd_en=0, mem_wb_en=1, mem_dst=5, ID src_2=5, id_two_src=1 -> hazard=1, bubble inserted.
//    With id_two_src=0 -> hazard=0.
//  - Branch flush with a simultaneous hazard condition: branch_taken=1 -> hazard=0,
//    a bubble is loaded, flush_cnt=1, stall_cnt unchanged.
//  - Saturation: CNT_W=2, force 5 consecutive hazards -> stall_cnt stops at 3.
//    Reset mid-stall -> stall_cnt=0, ex_valid=0.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with RAW hazard detection, bubble insertion
// and saturating stall/flush counters.
module id_ex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_en,
    input  logic              branch_taken,
    input  logic              id_valid,
    input  logic [3:0]        id_src_1,
    input  logic [3:0]        id_src_2,
    input  logic              id_two_src,
    input  logic [3:0]        id_dst,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [3:0]        id_exe_cmd,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [11:0]       id_shift_op,
    input  logic [23:0]       id_simm24,
    input  logic [3:0]        id_status,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [3:0]        mem_dst,
    input  logic              mem_wb_en,
    output logic              hazard,
    output logic              ex_valid,
    output logic [3:0]        ex_src_1,
    output logic [3:0]        ex_src_2,
    output logic              ex_two_src,
    output logic [3:0]        ex_dst,
    output logic              ex_wb_en,
    output logic              ex_mem_r_en,
    output logic              ex_mem_w_en,
    output logic              ex_b,
    output logic              ex_s,
    output logic              ex_imm,
    output logic [3:0]        ex_exe_cmd,
    output logic [DATA_W-1:0] ex_val_rn,
    output logic [DATA_W-1:0] ex_val_rm,
    output logic [11:0]       ex_shift_op,
    output logic [23:0]       ex_simm24,
    output logic [3:0]        ex_status,
    output logic [DATA_W-1:0] ex_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        src_1;
        logic [3:0]        src_2;
        logic              two_src;
        logic [3:0]        dst;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic              imm;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift_op;
        logic [23:0]       simm24;
        logic [3:0]        status;
        logic [DATA_W-1:0] pc;
    } id_ex_t;

    id_ex_t id_d;
    id_ex_t ex_q;

    assign id_d = '{
        valid:    id_valid,
        src_1:    id_src_1,
        src_2:    id_src_2,
        two_src:  id_two_src,
        dst:      id_dst,
        wb_en:    id_wb_en,
        mem_r_en: id_mem_r_en,
        mem_w_en: id_mem_w_en,
        b:        id_b,
        s:        id_s,
        imm:      id_imm,
        exe_cmd:  id_exe_cmd,
        val_rn:   id_val_rn,
        val_rm:   id_val_rm,
        shift_op: id_shift_op,
        simm24:   id_simm24,
        status:   id_status,
        pc:       id_pc
    };

    logic chk_1;
    logic chk_2;
    logic ex_hit_1;
    logic ex_hit_2;
    logic mem_hit_1;
    logic mem_hit_2;
    logic raw;

    always_comb begin
        chk_1     = id_valid & ~id_b;
        chk_2     = id_valid & id_two_src;
        ex_hit_1  = ex_q.valid & ex_q.wb_en & (id_src_1 == ex_q.dst);
        ex_hit_2  = ex_q.valid & ex_q.wb_en & (id_src_2 == ex_q.dst);
        mem_hit_1 = mem_wb_en & (id_src_1 == mem_dst);
        mem_hit_2 = mem_wb_en & (id_src_2 == mem_dst);
        // With forwarding only a load in EX cannot be bypassed in time
        if (fwd_en) begin
            raw = ex_q.mem_r_en
                & ((chk_1 & ex_hit_1) | (chk_2 & ex_hit_2));
        end else begin
            raw = (chk_1 & (ex_hit_1 | mem_hit_1))
                | (chk_2 & (ex_hit_2 | mem_hit_2));
        end
        hazard = raw & ~branch_taken & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (branch_taken) begin
            ex_q <= '0;
            if (flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end else if (hazard) begin
            ex_q <= '0;
            if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            ex_q <= id_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_src_1    = ex_q.src_1;
    assign ex_src_2    = ex_q.src_2;
    assign ex_two_src  = ex_q.two_src;
    assign ex_dst      = ex_q.dst;
    assign ex_wb_en    = ex_q.wb_en;
    assign ex_mem_r_en = ex_q.mem_r_en;
    assign ex_mem_w_en = ex_q.mem_w_en;
    assign ex_b        = ex_q.b;
    assign ex_s        = ex_q.s;
    assign ex_imm      = ex_q.imm;
    assign ex_exe_cmd  = ex_q.exe_cmd;
    assign ex_val_rn   = ex_q.val_rn;
    assign ex_val_rm   = ex_q.val_rm;
    assign ex_shift_op = ex_q.shift_op;
    assign ex_simm24   = ex_q.simm24;
    assign ex_status   = ex_q.status;
    assign ex_pc       = ex_q.pc;

endmodule
